data_reshuffler_stream_gate: RTL and testbench

Upstream stage of the data reshuffler. It sits between the streamer read port and the reshuffler input and turns an open-ended stream into bounded transfers. Each transfer is configured through a CSR handshake with a beat count and a transpose flag. The block forwards exactly that many beats through a 2-entry registered buffer, holds the transpose flag stable for the whole transfer, and pulses done when the last beat has left.

---
 rtl/data_reshuffler_stream_gate.sv | 113 +++++++++++
 tb/tb_data_reshuffler_stream_gate.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_reshuffler_stream_gate.sv
// Stream gate in front of the data reshuffler: cuts an open-ended stream into
// CSR-configured transfers of N beats through a 2-entry registered buffer.
module data_reshuffler_stream_gate #(
    parameter int DataWidth  = 512,
    parameter int CountWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [CountWidth-1:0] csr_beats_i,
    input  logic                  csr_transpose_i,
    input  logic                  csr_valid_i,
    output logic                  csr_ready_o,
    input  logic [DataWidth-1:0]  stream2gate_data_i,
    input  logic                  stream2gate_valid_i,
    output logic                  stream2gate_ready_o,
    output logic [DataWidth-1:0]  gate2resh_data_o,
    output logic                  gate2resh_valid_o,
    input  logic                  gate2resh_ready_i,
    output logic                  gate2resh_transpose_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CountWidth-1:0] beats_out_o
);

    localparam logic [0:0] Idle   = 1'b0;
    localparam logic [0:0] Stream = 1'b1;
    localparam logic [CountWidth-1:0] One = 1;

    logic [0:0]            state_q;
    logic                  init_q;
    logic                  done_q;
    logic                  transpose_q;
    logic [CountWidth-1:0] beats_q;
    logic [CountWidth-1:0] in_cnt_q;
    logic [CountWidth-1:0] out_cnt_q;
    logic [DataWidth-1:0]  mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            fifo_cnt_q;
    logic                  csr_fire;
    logic                  push;
    logic                  pop;
    logic                  last_pop;

    // init_q keeps csr_ready low while in reset so every output reads 0 there.
    assign csr_ready_o         = init_q & (state_q == Idle);
    assign csr_fire            = csr_valid_i & csr_ready_o;
    assign stream2gate_ready_o = (state_q == Stream) & (fifo_cnt_q != 2'd2) & (in_cnt_q < beats_q);
    assign push                = stream2gate_valid_i & stream2gate_ready_o;
    assign gate2resh_valid_o   = (fifo_cnt_q != 2'd0);
    assign pop                 = gate2resh_valid_o & gate2resh_ready_i;
    assign last_pop            = pop & ((out_cnt_q + One) == beats_q);

    assign gate2resh_data_o      = mem_q[rd_ptr_q];
    assign gate2resh_transpose_o = transpose_q;
    assign busy_o                = (state_q == Stream);
    assign done_o                = done_q;
    assign beats_out_o           = out_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= stream2gate_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            init_q      <= 1'b0;
            done_q      <= 1'b0;
            transpose_q <= 1'b0;
            beats_q     <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
        end else begin
            init_q <= 1'b1;
            done_q <= 1'b0;
            if (state_q == Idle) begin
                if (csr_fire) begin
                    beats_q     <= csr_beats_i;
                    transpose_q <= csr_transpose_i;
                    in_cnt_q    <= '0;
                    out_cnt_q   <= '0;
                    // An empty transfer completes immediately without streaming.
                    if (csr_beats_i == '0) done_q  <= 1'b1;
                    else                   state_q <= Stream;
                end
            end else begin
                if (push) in_cnt_q  <= in_cnt_q + One;
                if (pop)  out_cnt_q <= out_cnt_q + One;
                if (last_pop) begin
                    state_q <= Idle;
                    done_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_reshuffler_stream_gate.sv
// Bench for the stream gate: randomized streamer/reshuffler traffic checked
// against a transfer-level model and an expected-beat scoreboard.
module tb_data_reshuffler_stream_gate;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] csr_beats = '0;
    logic          csr_tr = 1'b0;
    logic          csr_valid = 1'b0;
    logic          csr_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic          r_tr;
    logic          busy;
    logic          done;
    logic [CW-1:0] beats_out;

    data_reshuffler_stream_gate #(.DataWidth(DW), .CountWidth(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .csr_beats_i(csr_beats), .csr_transpose_i(csr_tr),
        .csr_valid_i(csr_valid), .csr_ready_o(csr_ready),
        .stream2gate_data_i(s_data), .stream2gate_valid_i(s_valid),
        .stream2gate_ready_o(s_ready),
        .gate2resh_data_o(r_data), .gate2resh_valid_o(r_valid),
        .gate2resh_ready_i(r_ready), .gate2resh_transpose_o(r_tr),
        .busy_o(busy), .done_o(done), .beats_out_o(beats_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int rmode = 0;
    int vmode = 0;

    // Transfer-level model of the block, valid for the current cycle.
    logic m_busy = 1'b0, m_done = 1'b0, m_tr = 1'b0, m_init = 1'b0;
    int   m_beats = 0, m_in = 0, m_out = 0;
    int   acc_cnt = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Streamer and reshuffler drivers.
    initial begin
        forever begin
            @(posedge clk); #1;
            s_valid = (src_q.size() > 0) && (vmode == 0 || $urandom_range(0, 3) != 0);
            if (src_q.size() > 0) s_data = src_q[0];
            else                  s_data = '0;
            case (rmode)
                0:       r_ready = 1'b1;
                1:       r_ready = ~r_ready;
                default: r_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare this cycle against the model, then advance the model.
    always @(negedge clk) begin : mon
        logic exp_val, exp_srdy, in_fire, out_fire, nb, nd;
        if (rst_n) begin
            exp_val  = (m_in - m_out) > 0;
            exp_srdy = m_busy && (m_in - m_out) < 2 && m_in < m_beats;
            chk("busy", DW'(busy), DW'(m_busy));
            chk("done", DW'(done), DW'(m_done));
            chk("csr_ready", DW'(csr_ready), DW'(!m_busy && m_init));
            chk("stream_ready", DW'(s_ready), DW'(exp_srdy));
            chk("out_valid", DW'(r_valid), DW'(exp_val));
            chk("transpose", DW'(r_tr), DW'(m_tr));
            chk("beats_out", DW'(beats_out), DW'(m_out));
            if (exp_val) begin
                if (exp_q.size() == 0) timeout("scoreboard_empty");
                else chk("out_data", r_data, exp_q[0]);
            end
            in_fire  = exp_srdy && s_valid;
            out_fire = exp_val && r_ready;
            nb = m_busy;
            nd = 1'b0;
            if (!m_busy && m_init && csr_valid) begin
                m_beats = int'(csr_beats);
                m_tr    = csr_tr;
                m_in    = 0;
                m_out   = 0;
                for (int i = 0; i < m_beats && i < src_q.size(); i++) exp_q.push_back(src_q[i]);
                if (m_beats == 0) nd = 1'b1;
                else              nb = 1'b1;
                acc_cnt++;
            end else if (m_busy) begin
                if (in_fire) begin
                    m_in++;
                    void'(src_q.pop_front());
                end
                if (out_fire) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_out++;
                    if (m_out == m_beats) begin
                        nb = 1'b0;
                        nd = 1'b1;
                    end
                end
            end
            if (m_done) done_cnt++;
            m_busy = nb;
            m_done = nd;
            m_init = 1'b1;
        end
    end

    task automatic cfg(input int beats, input bit tr);
        int  start;
        bit  ok;
        for (int i = 0; i < beats + 2; i++) src_q.push_back({$urandom, $urandom});
        @(posedge clk); #1;
        csr_beats = CW'(beats);
        csr_tr    = tr;
        csr_valid = 1'b1;
        start = acc_cnt;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk); #1;
            if (acc_cnt != start) ok = 1'b1;
        end
        csr_valid = 1'b0;
        if (!ok) timeout("csr_accept");
    endtask

    task automatic wait_done();
        int  start;
        bit  ok;
        start = done_cnt;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk); #1;
            if (done_cnt != start) ok = 1'b1;
        end
        if (!ok) timeout("wait_done");
    endtask

    task automatic reset_checks();
        chk("rst_busy", DW'(busy), '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_csr_ready", DW'(csr_ready), '0);
        chk("rst_stream_ready", DW'(s_ready), '0);
        chk("rst_valid", DW'(r_valid), '0);
        chk("rst_data", r_data, '0);
        chk("rst_transpose", DW'(r_tr), '0);
        chk("rst_beats_out", DW'(beats_out), '0);
    endtask

    initial begin
        #12;
        reset_checks();
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Back-to-back streaming, 4 beats, transpose on.
        rmode = 0; vmode = 0;
        cfg(4, 1'b1);
        wait_done();
        chk("t1_beats_out", DW'(beats_out), DW'(4));

        // Reshuffler ready toggling, 8 beats.
        rmode = 1;
        cfg(8, 1'b0);
        wait_done();
        chk("t2_beats_out", DW'(beats_out), DW'(8));

        // Empty transfer.
        rmode = 0;
        cfg(0, 1'b1);
        wait_done();
        chk("t3_beats_out", DW'(beats_out), '0);

        // Second config requested mid-transfer, taken in the done cycle.
        cfg(3, 1'b1);
        cfg(2, 1'b0);
        wait_done();
        chk("t4_beats_out", DW'(beats_out), DW'(2));

        // Asynchronous reset after two of six beats delivered.
        cfg(6, 1'b1);
        begin : wait_two
            bit ok;
            ok = 1'b0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(posedge clk); #2;
                if (m_out == 2) ok = 1'b1;
            end
            if (!ok) timeout("wait_two_beats");
        end
        rst_n = 1'b0;
        #1;
        reset_checks();
        m_busy = 1'b0; m_done = 1'b0; m_tr = 1'b0; m_init = 1'b0;
        m_beats = 0; m_in = 0; m_out = 0;
        exp_q.delete();
        src_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cfg(1, 1'b0);
        wait_done();
        chk("t5_beats_out", DW'(beats_out), DW'(1));

        // Randomized transfers.
        for (int t = 0; t < 12; t++) begin
            rmode = $urandom_range(0, 2);
            vmode = $urandom_range(0, 1);
            cfg($urandom_range(0, 12), 1'($urandom_range(0, 1)));
            wait_done();
        end
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
